// File: rtl/bb_capture_fifo.sv
// Capture FIFO: buffers {x,y} samples between start and stop, drains them afterwards, counts x/y hits.
// Latency: a push appears on out_valid/out_data one cycle later; no fall-through.
// Backpressure: in_ready only in CAPTURE while not full; out_ready stalls the head in any state.

// Generic circular FIFO with an occupancy counter one bit wider than the pointers.
// Latency: 1 cycle write-to-read; head is read straight from storage.
// Backpressure: wr_rdy drops when full (pops never free a slot in the same cycle); rd_vld when empty.
module bb_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module bb_capture_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    logic   fifo_wr_rdy;
    logic   capturing;
    logic   push;

    assign capturing = (state == CAPTURE);
    assign in_ready  = capturing && fifo_wr_rdy;
    assign push      = in_valid && in_ready;

    bb_fifo #(
        .WIDTH (2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (in_valid && capturing),
        .wr_dat ({x, y}),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (out_valid),
        .rd_dat (out_data),
        .rd_rdy (out_ready)
    );

    // DRAIN leaves on the registered empty flag, i.e. the cycle after the last pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // clr wins over any same-cycle increment or overflow set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && x && (x_cnt != CNT_MAX)) begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (push && y && (y_cnt != CNT_MAX)) begin
                y_cnt <= y_cnt + 1'b1;
            end
            if (in_valid && capturing && !fifo_wr_rdy) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bb_capture_fifo.sv
// Directed bench for bb_capture_fifo: one DEPTH=8/CNT_W=8 instance plus a CNT_W=2 instance for saturation.
module tb_bb_capture_fifo;
    logic       clk;
    logic       rst_n;
    logic       start, stop, clr, in_valid, x, y, out_ready;
    logic       in_ready, out_valid, overflow, busy;
    logic [1:0] out_data;
    logic [7:0] x_cnt, y_cnt;

    logic       s_start, s_stop, s_clr, s_in_valid, s_x, s_y, s_out_ready;
    logic       s_in_ready, s_out_valid, s_overflow, s_busy;
    logic [1:0] s_out_data;
    logic [1:0] s_x_cnt, s_y_cnt;

    int checks   = 0;
    int failures = 0;

    logic [1:0] v1 [4];
    logic [1:0] d3 [20];
    logic [2:0] jj;

    bb_capture_fifo #(.DEPTH(8), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .clr       (clr),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .x_cnt     (x_cnt),
        .y_cnt     (y_cnt),
        .overflow  (overflow),
        .busy      (busy)
    );

    bb_capture_fifo #(.DEPTH(8), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .stop      (s_stop),
        .clr       (s_clr),
        .in_valid  (s_in_valid),
        .x         (s_x),
        .y         (s_y),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .x_cnt     (s_x_cnt),
        .y_cnt     (s_y_cnt),
        .overflow  (s_overflow),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {start, stop, clr, in_valid, x, y, out_ready} = '0;
        {s_start, s_stop, s_clr, s_in_valid, s_x, s_y, s_out_ready} = '0;
        v1[0] = 2'b11; v1[1] = 2'b10; v1[2] = 2'b01; v1[3] = 2'b00;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x_cnt", x_cnt, 0);
        chk("rst_y_cnt", y_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_data", out_data, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // stop in IDLE does nothing
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);

        // Ordered capture of four samples, then in-order pops
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            {x, y} = v1[i];
            if (i == 0) chk("t1_no_fallthrough", out_valid, 0);
            tick();
            if (i == 0) begin
                chk("t1_lat1_valid", out_valid, 1);
                chk("t1_lat1_data", out_data, 3);
            end
        end
        in_valid = 1'b0;
        chk("t1_x_cnt", x_cnt, 2);
        chk("t1_y_cnt", y_cnt, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_pop_valid", out_valid, 1);
            chk("t1_pop_data", out_data, v1[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("t1_empty", out_valid, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t1_drain_busy", busy, 1);
        tick();
        chk("t1_idle_busy", busy, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Fill to full, offer a ninth, check overflow and clr
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            jj = 3'(i);
            in_valid = 1'b1;
            x = jj[0];
            y = jj[1];
            tick();
            if (i == 7) begin
                chk("t2_full_in_ready", in_ready, 0);
                chk("t2_no_ovf_yet", overflow, 0);
            end
        end
        in_valid = 1'b0;
        chk("t2_overflow", overflow, 1);
        chk("t2_x_cnt", x_cnt, 4);
        chk("t2_y_cnt", y_cnt, 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t2_clr_overflow", overflow, 0);
        chk("t2_clr_x_cnt", x_cnt, 0);
        chk("t2_clr_y_cnt", y_cnt, 0);
        chk("t2_still_full", in_ready, 0);
        chk("t2_still_valid", out_valid, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            jj = 3'(j);
            chk("t2_pop_data", out_data, {jj[0], jj[1]});
            tick();
        end
        out_ready = 1'b0;
        chk("t2_drained", out_valid, 0);
        chk("t2_drain_busy", busy, 1);
        tick();
        chk("t2_idle", busy, 0);

        // Streaming with simultaneous push/pop across pointer wrap
        pulse_start();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            jj = 3'(k);
            d3[k] = {jj[0] ^ jj[1], jj[2]};
            in_valid = 1'b1;
            {x, y} = d3[k];
            tick();
            chk("t3_valid", out_valid, 1);
            chk("t3_data", out_data, d3[k]);
            chk("t3_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t3_empty", out_valid, 0);
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("t3_idle", busy, 0);

        // Three samples, stop, ignored start during DRAIN, drain back to IDLE
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            {x, y} = v1[i + 1];
            tick();
        end
        in_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_in_ready", in_ready, 0);
        pulse_start();
        chk("t4_start_ignored", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_pop_data", out_data, v1[i + 1]);
            tick();
        end
        out_ready = 1'b0;
        chk("t4_last_pop_busy", busy, 1);
        tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_in_ready", in_ready, 0);

        // Saturation on the narrow-counter instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_in_valid = 1'b1;
        s_x = 1'b1;
        s_y = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        s_in_valid = 1'b0;
        chk("t5_sat_x_cnt", s_x_cnt, 3);
        chk("t5_sat_y_cnt", s_y_cnt, 3);

        // Async reset with five entries buffered
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulse_start();
        in_valid = 1'b1;
        x = 1'b1;
        y = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        chk("t6_pre_x_cnt", x_cnt, 5);
        chk("t6_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_x_cnt", x_cnt, 0);
        chk("t6_rst_y_cnt", y_cnt, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_out_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
